// File: rtl/lsu_pkg.sv
// Shared types for the load/store stage: opcode and FSM encodings plus opcode classifiers.
package lsu_pkg;

  localparam int XLEN  = 64;
  localparam int MASKW = XLEN / 8;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LD   = 4'd4,
    LBU  = 4'd5,
    LHU  = 4'd6,
    LWU  = 4'd7,
    SB   = 4'd9,
    SH   = 4'd10,
    SW   = 4'd11,
    SD   = 4'd12
  } lsop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic logic is_load(input lsop_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LD) ||
           (op == LBU) || (op == LHU) || (op == LWU);
  endfunction

  function automatic logic is_store(input lsop_t op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/data shifted into lane, load data shifted down and extended.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MASKW = XLEN / 8,
  parameter int OFFW  = $clog2(MASKW)
) (
  input  lsop_t             lsop,
  input  logic [OFFW-1:0]   off,
  input  logic [XLEN-1:0]   stdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASKW-1:0]  wmask,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ld_res
);

  logic [MASKW-1:0] base_mask;
  logic [XLEN-1:0]  rshift;

  always_comb begin
    base_mask = '0;
    case (lsop)
      SB:      base_mask = MASKW'(8'h01);
      SH:      base_mask = MASKW'(8'h03);
      SW:      base_mask = MASKW'(8'h0F);
      SD:      base_mask = '1;
      default: base_mask = '0;
    endcase
  end

  // Lanes shifted past the top of the doubleword simply fall off.
  assign wmask  = base_mask << off;
  assign wdata  = stdata << {off, 3'b000};
  assign rshift = rdata >> {off, 3'b000};

  always_comb begin
    ld_res = '0;
    case (lsop)
      LB:      ld_res = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
      LH:      ld_res = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      LW:      ld_res = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
      LBU:     ld_res = {{(XLEN-8){1'b0}},        rshift[7:0]};
      LHU:     ld_res = {{(XLEN-16){1'b0}},       rshift[15:0]};
      LWU:     ld_res = {{(XLEN-32){1'b0}},       rshift[31:0]};
      LD:      ld_res = rshift;
      default: ld_res = '0;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Single-entry load/store stage: latches one EXU instruction, performs at most one bus access.
// Latency: 1 cycle for ALU ops, 3 cycles for memory ops with an immediate gnt/rvalid.
// Backpressure: o_pre_ready only in IDLE or when HOLD drains this cycle; HOLD waits on i_post_ready.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MASKW = XLEN / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic              i_rdwen,
  input  logic [XLEN-1:0]   i_exu_res,
  input  lsop_t             i_lsop,
  input  logic [XLEN-1:0]   i_stdata,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic              o_rdwen,
  output logic [XLEN-1:0]   o_exu_res,
  output logic [XLEN-1:0]   o_lsu_res,
  output logic              o_ldflag,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [MASKW-1:0]  o_mem_wmask,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int OFFW = $clog2(MASKW);

  state_t          state_q, state_nxt;
  lsop_t           lsop_q;
  logic [XLEN-1:0] stdata_q;
  logic [XLEN-1:0] ld_res;
  logic            accept;
  logic            rsp_fire;

  always_comb begin
    state_nxt    = state_q;
    o_pre_ready  = 1'b0;
    o_post_valid = 1'b0;
    o_mem_req    = 1'b0;
    rsp_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        o_pre_ready = 1'b1;
        if (i_pre_valid) state_nxt = (i_lsop != NONE) ? REQ : HOLD;
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        rsp_fire = i_mem_rvalid;
        if (i_mem_rvalid) state_nxt = HOLD;
      end
      HOLD: begin
        o_post_valid = 1'b1;
        o_pre_ready  = i_post_ready;
        if (i_post_ready) begin
          if (i_pre_valid) state_nxt = (i_lsop != NONE) ? REQ : HOLD;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = i_pre_valid & o_pre_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      lsop_q    <= NONE;
      stdata_q  <= '0;
      o_rdwen   <= 1'b0;
      o_exu_res <= '0;
      o_lsu_res <= '0;
      o_ldflag  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        lsop_q    <= i_lsop;
        stdata_q  <= i_stdata;
        o_rdwen   <= i_rdwen;
        o_exu_res <= i_exu_res;
        o_ldflag  <= is_load(i_lsop);
        o_lsu_res <= '0;
      end else if (rsp_fire) begin
        // Store acks leave the result at zero.
        o_lsu_res <= o_ldflag ? ld_res : '0;
      end
    end
  end

  // Bus fields derive only from registered state, so they stay constant through REQ stalls.
  assign o_mem_wen  = is_store(lsop_q);
  assign o_mem_addr = {o_exu_res[XLEN-1:OFFW], {OFFW{1'b0}}};

  lsu_align #(
    .XLEN  (XLEN),
    .MASKW (MASKW),
    .OFFW  (OFFW)
  ) u_align (
    .lsop   (lsop_q),
    .off    (o_exu_res[OFFW-1:0]),
    .stdata (stdata_q),
    .rdata  (i_mem_rdata),
    .wmask  (o_mem_wmask),
    .wdata  (o_mem_wdata),
    .ld_res (ld_res)
  );

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage with hand-computed expectations.
module tb_lsu_stage;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic        i_rdwen;
  logic [63:0] i_exu_res;
  lsop_t       i_lsop;
  logic [63:0] i_stdata;
  logic        o_post_valid;
  logic        i_post_ready;
  logic        o_rdwen;
  logic [63:0] o_exu_res;
  logic [63:0] o_lsu_res;
  logic        o_ldflag;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  lsu_stage #(.XLEN(64), .MASKW(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_rdwen      (i_rdwen),
    .i_exu_res    (i_exu_res),
    .i_lsop       (i_lsop),
    .i_stdata     (i_stdata),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_rdwen      (o_rdwen),
    .o_exu_res    (o_exu_res),
    .o_lsu_res    (o_lsu_res),
    .o_ldflag     (o_ldflag),
    .o_mem_req    (o_mem_req),
    .o_mem_wen    (o_mem_wen),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input lsop_t op, input logic [63:0] addr,
                       input logic [63:0] std, input logic rdwen);
    i_pre_valid = 1'b1;
    i_lsop      = op;
    i_exu_res   = addr;
    i_stdata    = std;
    i_rdwen     = rdwen;
  endtask

  // Runs one memory op through REQ/WAIT with immediate gnt and rvalid; ends in HOLD.
  task automatic mem_quick(input lsop_t op, input logic [63:0] addr,
                           input logic [63:0] std, input logic [63:0] rdata);
    issue(op, addr, std, 1'b1);
    i_mem_gnt = 1'b1;
    step();
    i_pre_valid = 1'b0;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rdata;
    step();
    i_mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_pre_valid = 1'b0; i_rdwen = 1'b0; i_exu_res = '0;
    i_lsop = NONE; i_stdata = '0; i_post_ready = 1'b1;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    step(); step();
    i_rst = 1'b0;

    chk("rst_pre_ready",  o_pre_ready,  1'b1);
    chk("rst_post_valid", o_post_valid, 1'b0);
    chk("rst_mem_req",    o_mem_req,    1'b0);
    chk("rst_exu_res",    o_exu_res,    64'h0);
    chk("rst_lsu_res",    o_lsu_res,    64'h0);
    chk("rst_ldflag",     o_ldflag,     1'b0);
    chk("rst_rdwen",      o_rdwen,      1'b0);

    // ALU op: one-cycle latency, no bus activity
    issue(NONE, 64'h1234, 64'h0, 1'b1);
    step();
    i_pre_valid = 1'b0;
    chk("alu_post_valid", o_post_valid, 1'b1);
    chk("alu_exu_res",    o_exu_res,    64'h1234);
    chk("alu_ldflag",     o_ldflag,     1'b0);
    chk("alu_lsu_res",    o_lsu_res,    64'h0);
    chk("alu_mem_req",    o_mem_req,    1'b0);
    chk("alu_rdwen",      o_rdwen,      1'b1);
    step();
    chk("alu_drained",    o_post_valid, 1'b0);

    // LB, checked cycle by cycle for the 3-cycle latency
    issue(LB, 64'h8000_0003, 64'h0, 1'b1);
    i_mem_gnt = 1'b1;
    step();
    i_pre_valid = 1'b0;
    chk("lb_req",        o_mem_req,   1'b1);
    chk("lb_addr",       o_mem_addr,  64'h8000_0000);
    chk("lb_wen",        o_mem_wen,   1'b0);
    chk("lb_pre_ready",  o_pre_ready, 1'b0);
    chk("lb_post_valid", o_post_valid, 1'b0);
    step();
    i_mem_gnt = 1'b0;
    chk("lb_wait_req",   o_mem_req,   1'b0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'h0000_0000_8000_0000;
    step();
    i_mem_rvalid = 1'b0;
    chk("lb_post_valid_hold", o_post_valid, 1'b1);
    chk("lb_lsu_res",    o_lsu_res,   64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ldflag",     o_ldflag,    1'b1);
    step();

    mem_quick(LBU, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000);
    chk("lbu_lsu_res", o_lsu_res, 64'h80);
    step();
    mem_quick(LH, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000);
    chk("lh_lsu_res",  o_lsu_res, 64'hFFFF_FFFF_FFFF_8001);
    step();
    // Word straddling lane 7: missing top byte reads as 0, so the sign bit is clear
    mem_quick(LW, 64'h8000_0005, 64'h0, 64'hFF00_0000_0000_0000);
    chk("lw_past_lane7", o_lsu_res, 64'h0000_0000_00FF_0000);
    step();
    mem_quick(LWU, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000);
    chk("lwu_lsu_res", o_lsu_res, 64'h0000_0000_8765_4321);
    step();
    mem_quick(LD, 64'h8000_0008, 64'h0, 64'hDEAD_BEEF_0123_4567);
    chk("ld_lsu_res",  o_lsu_res, 64'hDEAD_BEEF_0123_4567);
    chk("ld_exu_res",  o_exu_res, 64'h8000_0008);
    step();

    // SH into the top lanes
    issue(SH, 64'h8000_0006, 64'hBEEF, 1'b0);
    i_mem_gnt = 1'b1;
    step();
    i_pre_valid = 1'b0;
    chk("sh_wen",   o_mem_wen,   1'b1);
    chk("sh_wmask", o_mem_wmask, 8'hC0);
    chk("sh_wdata", o_mem_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_addr",  o_mem_addr,  64'h8000_0000);
    step();
    i_mem_gnt = 1'b0;
    chk("sh_no_early_valid", o_post_valid, 1'b0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    i_mem_rvalid = 1'b0;
    chk("sh_post_valid", o_post_valid, 1'b1);
    chk("sh_rdwen",      o_rdwen,      1'b0);
    chk("sh_lsu_res",    o_lsu_res,    64'h0);
    chk("sh_ldflag",     o_ldflag,     1'b0);
    step();

    // SW straddling lane 7: upper bytes dropped from both mask and data
    issue(SW, 64'h46, 64'h1122_3344, 1'b0);
    step();
    i_pre_valid = 1'b0;
    chk("sw_wmask", o_mem_wmask, 8'hC0);
    chk("sw_wdata", o_mem_wdata, 64'h3344_0000_0000_0000);
    chk("sw_addr",  o_mem_addr,  64'h40);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1;
    step();
    i_mem_rvalid = 1'b0;
    step();

    // Bus stall: gnt low 4 cycles, rvalid 3 cycles after gnt
    issue(SD, 64'h10, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    step();
    i_pre_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_req",       o_mem_req,   1'b1);
      chk("stall_addr",      o_mem_addr,  64'h10);
      chk("stall_wdata",     o_mem_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
      chk("stall_wmask",     o_mem_wmask, 8'hFF);
      chk("stall_pre_ready", o_pre_ready, 1'b0);
      step();
    end
    i_mem_gnt = 1'b1;
    chk("stall_req_at_gnt", o_mem_req, 1'b1);
    step();
    i_mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("stall_wait_req",   o_mem_req,    1'b0);
      chk("stall_wait_ready", o_pre_ready,  1'b0);
      chk("stall_wait_valid", o_post_valid, 1'b0);
      step();
    end
    i_mem_rvalid = 1'b1;
    step();
    i_mem_rvalid = 1'b0;
    chk("stall_hold_valid", o_post_valid, 1'b1);
    chk("stall_hold_ready", o_pre_ready,  1'b1);
    step();

    // Back-to-back ALU ops
    for (int k = 0; k < 5; k++) begin
      issue(NONE, 64'h100 + 64'(k), 64'h0, 1'b1);
      step();
      chk("b2b_valid", o_post_valid, 1'b1);
      chk("b2b_order", o_exu_res,    64'h100 + 64'(k));
    end
    issue(NONE, 64'h999, 64'h0, 1'b1);
    i_post_ready = 1'b0;
    #1;
    chk("bp_pre_ready", o_pre_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_valid",     o_post_valid, 1'b1);
      chk("bp_held",      o_exu_res,    64'h104);
      chk("bp_pre_ready", o_pre_ready,  1'b0);
    end
    i_pre_valid  = 1'b0;
    i_post_ready = 1'b1;
    step();
    chk("bp_drain", o_post_valid, 1'b0);

    // Reset while waiting for the response
    issue(LW, 64'h20, 64'h0, 1'b1);
    i_mem_gnt = 1'b1;
    step();
    i_pre_valid = 1'b0;
    step();
    i_mem_gnt = 1'b0;
    chk("rw_in_wait", o_mem_req, 1'b0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rw_post_valid", o_post_valid, 1'b0);
    chk("rw_mem_req",    o_mem_req,    1'b0);
    chk("rw_pre_ready",  o_pre_ready,  1'b1);
    chk("rw_ldflag",     o_ldflag,     1'b0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'h1234_5678_9ABC_DEF0;
    step();
    i_mem_rvalid = 1'b0;
    chk("late_rvalid_valid", o_post_valid, 1'b0);
    chk("late_rvalid_res",   o_lsu_res,    64'h0);
    step();
    chk("late_rvalid_idle",  o_pre_ready,  1'b1);
    chk("late_rvalid_none",  o_post_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
